fifo_traffic_gen: RTL and testbench



---
 rtl/fifo_tg_pkg.sv | 31 +++
 rtl/fifo_tg_lfsr.sv | 22 ++
 rtl/fifo_traffic_gen.sv | 170 +++++++++++++++++
 tb/tb_fifo_traffic_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tg_pkg.sv
// Shared types and helpers for the FIFO traffic generator.
// Build option FIFO_TG_CHECK_EN enables the in-line read-data checker.
package fifo_tg_pkg;

  typedef enum logic [1:0] {
    MODE_FILL_DRAIN = 2'd0,
    MODE_STREAM     = 2'd1,
    MODE_RANDOM     = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_STREAM,
    S_RAND,
    S_DONE
  } state_e;

  localparam logic [7:0] LFSR_POLY_DEF = 8'hB8;
  localparam logic [7:0] LFSR_INIT     = 8'h01;

  // Right-shifting Galois step: feedback taps fold in when bit 0 falls out
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s,
    input logic [7:0] poly
  );
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

endpackage

// File: rtl/fifo_tg_lfsr.sv
// 8-bit Galois LFSR with advance enable and synchronous reset.
// Drives the write/read coin flips of the RANDOM traffic mode.
module fifo_tg_lfsr
  import fifo_tg_pkg::*;
#(
  parameter logic [7:0] POLY = LFSR_POLY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_INIT;
    end else if (adv) begin
      q <= lfsr_next(q, POLY);
    end
  end

endmodule

// File: rtl/fifo_traffic_gen.sv
// Deterministic FIFO stimulus engine: FILL_DRAIN, STREAM and RANDOM runs.
// Build option FIFO_TG_CHECK_EN adds the error output and read-data compare.
module fifo_traffic_gen
  import fifo_tg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    NUM_TXN    = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = 4'h1,
  parameter logic [7:0]            LFSR_POLY  = LFSR_POLY_DEF,
  localparam int                   CNT_W      = $clog2(NUM_TXN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count
`ifdef FIFO_TG_CHECK_EN
  ,
  output logic                  error
`endif
);

  localparam logic [CNT_W-1:0] N_TXN = CNT_W'(NUM_TXN);

  state_e           state, state_d, entry_st;
  logic [7:0]       lfsr;
  logic             start_acc;
  logic             wr_acc, rd_acc;
  logic             wr_left, rd_left;
  logic             all_done;
  logic [CNT_W-1:0] wr_nxt, rd_nxt;

  assign start_acc = start && (state == S_IDLE || state == S_DONE);
  assign wr_left   = wr_count < N_TXN;
  assign rd_left   = rd_count < N_TXN;
  assign wr_acc    = write_en && (!full || read_en);
  assign rd_acc    = read_en && (!empty || write_en);
  assign wr_nxt    = wr_count + CNT_W'(wr_acc);
  assign rd_nxt    = rd_count + CNT_W'(rd_acc);
  assign all_done  = (wr_nxt == N_TXN) && (rd_nxt == N_TXN);

  // Reseeded on every accepted start so each run repeats exactly
  fifo_tg_lfsr #(
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk (clk),
    .rst (rst || start_acc),
    .adv (state == S_RAND),
    .q   (lfsr)
  );

  always_comb begin
    if (mode == MODE_FILL_DRAIN) begin
      entry_st = S_FILL;
    end else if (mode == MODE_RANDOM) begin
      entry_st = S_RAND;
    end else begin
      entry_st = S_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_d = entry_st;
      end
      S_FILL: begin
        if (all_done) begin
          state_d = S_DONE;
        end else if (full || wr_nxt == N_TXN) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (all_done) begin
          state_d = S_DONE;
        end else if (empty && wr_left) begin
          state_d = S_FILL;
        end
      end
      S_STREAM, S_RAND: begin
        if (all_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enables come from registered state only, never from full/empty
  always_comb begin
    write_en = 1'b0;
    read_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_FILL: begin
        write_en = 1'b1;
        busy     = 1'b1;
      end
      S_DRAIN: begin
        read_en = 1'b1;
        busy    = 1'b1;
      end
      S_STREAM: begin
        write_en = wr_left;
        read_en  = rd_left;
        busy     = 1'b1;
      end
      S_RAND: begin
        write_en = wr_left && (lfsr[0] || !rd_left);
        read_en  = rd_left && (lfsr[1] || !wr_left);
        busy     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      wr_count   <= '0;
      rd_count   <= '0;
      write_data <= SEED;
    end else begin
      if (wr_acc) begin
        wr_count   <= wr_nxt;
        write_data <= write_data + DATA_WIDTH'(1);
      end
      if (rd_acc) rd_count <= rd_nxt;
    end
  end

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr[7:2];

`ifdef FIFO_TG_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_data;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      error    <= 1'b0;
      exp_data <= SEED;
    end else if (rd_acc) begin
      if (read_data != exp_data) error <= 1'b1;
      exp_data <= exp_data + DATA_WIDTH'(1);
    end
  end
`else
  logic unused_read_data;
  assign unused_read_data = ^read_data;
`endif

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench for fifo_traffic_gen against a depth-8 FIFO model.
// Build with FIFO_TG_CHECK_EN to also exercise the error output.
module tb_fifo_traffic_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       full;
  logic       empty;
  logic [3:0] read_data;
  logic       write_en;
  logic [3:0] write_data;
  logic       read_en;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;
  logic [4:0] rd_count;
`ifdef FIFO_TG_CHECK_EN
  logic       error;
`endif

  fifo_traffic_gen #(
    .DATA_WIDTH (4),
    .NUM_TXN    (16),
    .SEED       (4'h1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .full       (full),
    .empty      (empty),
    .read_data  (read_data),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
`ifdef FIFO_TG_CHECK_EN
    ,
    .error      (error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-8 FIFO model with pass-through on empty and optional corruption
  logic       clr;
  logic       corrupt;
  logic [3:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  int         rd_num;
  logic [3:0] rd_log [32];
  logic       wr_a, rd_a, push, pop;

  assign full      = (cnt == 4'd8);
  assign empty     = (cnt == 4'd0);
  assign wr_a      = write_en && (!full || read_en);
  assign rd_a      = read_en && (!empty || write_en);
  assign push      = wr_a && !(rd_a && empty);
  assign pop       = rd_a && !empty;
  assign read_data = (corrupt && rd_num == 2) ? 4'hF
                   : (empty ? write_data : mem[rp]);

  always @(posedge clk) begin
    if (clr) begin
      cnt    <= 4'd0;
      wp     <= 3'd0;
      rp     <= 3'd0;
      rd_num <= 0;
    end else begin
      if (push) begin
        mem[wp] <= write_data;
        wp      <= wp + 3'd1;
      end
      if (pop) rp <= rp + 3'd1;
      cnt <= cnt + 4'(push) - 4'(pop);
      if (rd_a) begin
        if (rd_num < 32) rd_log[rd_num] <= read_data;
        rd_num <= rd_num + 1;
      end
    end
  end

  int viol;
  initial viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (write_en && wr_count == 5'd16) viol++;
      if (rd_count > wr_count) viol++;
    end
  end

  int total;
  int passed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    clr   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_log(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk(tag, 32'(rd_log[i]), 32'((i + 1) % 16));
    end
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr"}, 32'(wr_count), 32'd16);
    chk({tag, "_rd"}, 32'(rd_count), 32'd16);
    check_log({tag, "_log"});
  endtask

  initial begin
    int n;
    total   = 0;
    passed  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'd0;
    clr     = 1'b1;
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;

    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_re", 32'(read_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr", 32'(wr_count), 32'd0);
    chk("rst_rd", 32'(rd_count), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'h1);

    // STREAM with a start pulse while busy
    start_run(2'd1);
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_pt_empty", 32'(empty), 32'd1);
    chk("st_pt_re", 32'(read_en), 32'd1);
    chk("st_pt_we", 32'(write_en), 32'd1);
    chk("st_pt_data", 32'(read_data), 32'h1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        chk("st_wr5", 32'(wr_count), 32'd5);
        start = 1'b1;
        mode  = 2'd0;
      end else if (n == 6) begin
        start = 1'b0;
        chk("st_ign_wr", 32'(wr_count), 32'd6);
        chk("st_ign_rd", 32'(rd_count), 32'd6);
        chk("st_ign_re", 32'(read_en), 32'd1);
      end
    end
    chk("st_cycles_le18", 32'(n <= 18), 32'd1);
    check_end("st");

    // FILL_DRAIN restarting from DONE
    start_run(2'd0);
    chk("fd_done_clr", 32'(done), 32'd0);
    chk("fd_busy", 32'(busy), 32'd1);
    chk("fd_wdata", 32'(write_data), 32'h1);
    chk("fd_wr0", 32'(wr_count), 32'd0);
    chk("fd_we", 32'(write_en), 32'd1);
    chk("fd_re", 32'(read_en), 32'd0);
    n = 0;
    while (!full && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fd_full", 32'(full), 32'd1);
    chk("fd_full_wr", 32'(wr_count), 32'd8);
    chk("fd_full_rd", 32'(rd_count), 32'd0);
    chk("fd_full_wdata", 32'(write_data), 32'h9);
    chk("fd_full_re", 32'(read_en), 32'd0);
    wait_done(100);
    check_end("fd");

    // RANDOM: LFSR 01 then B8 gives write-only then idle
    start_run(2'd2);
    chk("rnd_we0", 32'(write_en), 32'd1);
    chk("rnd_re0", 32'(read_en), 32'd0);
    @(negedge clk);
    chk("rnd_we1", 32'(write_en), 32'd0);
    chk("rnd_re1", 32'(read_en), 32'd0);
    wait_done(1000);
    check_end("rnd");

    // Reset in DRAIN after five reads
    start_run(2'd0);
    n = 0;
    while (!(read_en && rd_count == 5'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dr_rd5", 32'(rd_count), 32'd5);
    chk("dr_re", 32'(read_en), 32'd1);
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    chk("dr_rst_we", 32'(write_en), 32'd0);
    chk("dr_rst_re", 32'(read_en), 32'd0);
    chk("dr_rst_busy", 32'(busy), 32'd0);
    chk("dr_rst_done", 32'(done), 32'd0);
    chk("dr_rst_wr", 32'(wr_count), 32'd0);
    chk("dr_rst_rd", 32'(rd_count), 32'd0);
    chk("dr_rst_wdata", 32'(write_data), 32'h1);

`ifdef FIFO_TG_CHECK_EN
    // Third read corrupted to F
    corrupt = 1'b1;
    start_run(2'd1);
    @(negedge clk);
    @(negedge clk);
    chk("err_before", 32'(error), 32'd0);
    @(negedge clk);
    chk("err_set", 32'(error), 32'd1);
    corrupt = 1'b0;
    wait_done(40);
    chk("err_done", 32'(done), 32'd1);
    chk("err_sticky", 32'(error), 32'd1);
    start_run(2'd1);
    chk("err_clr", 32'(error), 32'd0);
    wait_done(40);
    chk("err_clean_done", 32'(done), 32'd1);
    chk("err_clean", 32'(error), 32'd0);
`endif

    chk("protocol_viol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
